// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode plus a DEPTH-entry FIFO between fetch
// and dispatch. Each accepted {pc, inst} word is decoded combinationally and
// written to the tail slot. Dispatch reads the decoded head slot.
module decode_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [31:0]       in_inst,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_pop,
    output logic [ADDR_W-1:0] out_pc,
    output logic [5:0]        out_opt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_imm,
    output logic              out_is_ls,
    output logic              out_is_br,
    output logic              out_illegal,
    output logic [PTR_W:0]    count
);

    typedef enum logic [5:0] {
        OPT_NONE  = 6'd0,
        OPT_LUI   = 6'd1,  OPT_AUIPC = 6'd2,  OPT_JAL   = 6'd3,  OPT_JALR  = 6'd4,
        OPT_BEQ   = 6'd5,  OPT_BNE   = 6'd6,  OPT_BLT   = 6'd7,  OPT_BGE   = 6'd8,
        OPT_BLTU  = 6'd9,  OPT_BGEU  = 6'd10,
        OPT_LB    = 6'd11, OPT_LH    = 6'd12, OPT_LW    = 6'd13, OPT_LBU   = 6'd14,
        OPT_LHU   = 6'd15,
        OPT_SB    = 6'd16, OPT_SH    = 6'd17, OPT_SW    = 6'd18,
        OPT_ADDI  = 6'd19, OPT_SLTI  = 6'd20, OPT_SLTIU = 6'd21, OPT_XORI  = 6'd22,
        OPT_ORI   = 6'd23, OPT_ANDI  = 6'd24, OPT_SLLI  = 6'd25, OPT_SRLI  = 6'd26,
        OPT_SRAI  = 6'd27,
        OPT_ADD   = 6'd28, OPT_SUB   = 6'd29, OPT_SLL   = 6'd30, OPT_SLT   = 6'd31,
        OPT_SLTU  = 6'd32, OPT_XOR   = 6'd33, OPT_SRL   = 6'd34, OPT_SRA   = 6'd35,
        OPT_OR    = 6'd36, OPT_AND   = 6'd37
    } opt_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        opt_e              opt;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [31:0]       imm;
        logic              is_ls;
        logic              is_br;
        logic              illegal;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    // Instruction fields and immediate formats
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opc    = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_sh = {27'b0, in_inst[24:20]};

    entry_t dec;

    logic [PTR_W-1:0] head, tail;
    entry_t           mem [DEPTH];
    logic             push, pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_pop & out_valid;

    // Decode the incoming word; unknown encodings zero every field and flag illegal
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opt     = OPT_NONE;
        case (opc)
            7'b0110111: begin dec.opt = OPT_LUI;   dec.rd = in_inst[11:7]; dec.imm = imm_u; end
            7'b0010111: begin dec.opt = OPT_AUIPC; dec.rd = in_inst[11:7]; dec.imm = imm_u; end
            7'b1101111: begin dec.opt = OPT_JAL;   dec.rd = in_inst[11:7]; dec.imm = imm_j; end
            7'b1100111: begin
                dec.opt = OPT_JALR; dec.rd = in_inst[11:7]; dec.rs1 = in_inst[19:15]; dec.imm = imm_i;
                if (f3 != 3'b000) dec.illegal = 1'b1;
            end
            7'b1100011: begin
                dec.rs1 = in_inst[19:15]; dec.rs2 = in_inst[24:20]; dec.imm = imm_b; dec.is_br = 1'b1;
                case (f3)
                    3'b000:  dec.opt = OPT_BEQ;
                    3'b001:  dec.opt = OPT_BNE;
                    3'b100:  dec.opt = OPT_BLT;
                    3'b101:  dec.opt = OPT_BGE;
                    3'b110:  dec.opt = OPT_BLTU;
                    3'b111:  dec.opt = OPT_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.rd = in_inst[11:7]; dec.rs1 = in_inst[19:15]; dec.imm = imm_i; dec.is_ls = 1'b1;
                case (f3)
                    3'b000:  dec.opt = OPT_LB;
                    3'b001:  dec.opt = OPT_LH;
                    3'b010:  dec.opt = OPT_LW;
                    3'b100:  dec.opt = OPT_LBU;
                    3'b101:  dec.opt = OPT_LHU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec.rs1 = in_inst[19:15]; dec.rs2 = in_inst[24:20]; dec.imm = imm_s; dec.is_ls = 1'b1;
                case (f3)
                    3'b000:  dec.opt = OPT_SB;
                    3'b001:  dec.opt = OPT_SH;
                    3'b010:  dec.opt = OPT_SW;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.rd = in_inst[11:7]; dec.rs1 = in_inst[19:15]; dec.imm = imm_i;
                case (f3)
                    3'b000: dec.opt = OPT_ADDI;
                    3'b010: dec.opt = OPT_SLTI;
                    3'b011: dec.opt = OPT_SLTIU;
                    3'b100: dec.opt = OPT_XORI;
                    3'b110: dec.opt = OPT_ORI;
                    3'b111: dec.opt = OPT_ANDI;
                    3'b001: begin
                        dec.opt = OPT_SLLI; dec.imm = imm_sh;
                        if (f7 != 7'b0) dec.illegal = 1'b1;
                    end
                    default: begin
                        dec.opt = f7[5] ? OPT_SRAI : OPT_SRLI; dec.imm = imm_sh;
                        if ({f7[6], f7[4:0]} != 6'b0) dec.illegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                dec.rd = in_inst[11:7]; dec.rs1 = in_inst[19:15]; dec.rs2 = in_inst[24:20];
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  dec.opt = OPT_ADD;
                        3'b001:  dec.opt = OPT_SLL;
                        3'b010:  dec.opt = OPT_SLT;
                        3'b011:  dec.opt = OPT_SLTU;
                        3'b100:  dec.opt = OPT_XOR;
                        3'b101:  dec.opt = OPT_SRL;
                        3'b110:  dec.opt = OPT_OR;
                        default: dec.opt = OPT_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    dec.opt = OPT_SUB;
                end else if (f7 == 7'h20 && f3 == 3'b101) begin
                    dec.opt = OPT_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.opt   = OPT_NONE;
            dec.rd    = '0;
            dec.rs1   = '0;
            dec.rs2   = '0;
            dec.imm   = '0;
            dec.is_ls = 1'b0;
            dec.is_br = 1'b0;
        end
    end

    // Queue pointers and occupancy; reset beats the enable, flush beats push/pop
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage is not reset; only slots between head and tail are meaningful
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush && push) mem[tail] <= dec;
    end

    entry_t head_e;
    assign head_e      = mem[head];
    assign out_pc      = head_e.pc;
    assign out_opt     = head_e.opt;
    assign out_rd      = head_e.rd;
    assign out_rs1     = head_e.rs1;
    assign out_rs2     = head_e.rs2;
    assign out_imm     = head_e.imm;
    assign out_is_ls   = head_e.is_ls;
    assign out_is_br   = head_e.is_br;
    assign out_illegal = head_e.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue. Expected decode results
// come from a hand-written table; a queue model tracks accepted entries.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int NV    = 15;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_pop = 1'b0;
    logic [31:0] out_pc;
    logic [5:0]  out_opt;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic        out_is_ls, out_is_br, out_illegal;
    logic [2:0]  count;

    decode_queue #(.DEPTH(DEPTH), .PTR_W(2), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pop(out_pop), .out_pc(out_pc), .out_opt(out_opt),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_is_ls(out_is_ls), .out_is_br(out_is_br), .out_illegal(out_illegal),
        .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  opt;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        ls, br, ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          idx;
    } sb_t;

    vec_t        tbl [NV];
    sb_t         mq [$];
    logic [31:0] cur_pc = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input int opt, input int rd, input int rs1,
                                input int rs2, input logic [31:0] imm, input bit ls, input bit br, input bit ill);
        vec_t v;
        v.inst = inst; v.opt = 6'(opt); v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.imm = imm; v.ls = ls; v.br = br; v.ill = ill;
        return v;
    endfunction

    // One clock: check status, compare head on pop, drive inputs, update model
    task automatic cycle(input bit iv, input int idx, input bit op, input bit fl, input bit rdy, input bit rst);
        bit do_push, do_pop;
        vec_t e;
        check_eq("count", 64'(count), 64'(mq.size()));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        if (op && mq.size() != 0) begin
            e = tbl[mq[0].idx];
            check_eq("head_pc", 64'(out_pc), 64'(mq[0].pc));
            check_eq("head_opt", 64'(out_opt), 64'(e.opt));
            check_eq("head_rd", 64'(out_rd), 64'(e.rd));
            check_eq("head_rs1", 64'(out_rs1), 64'(e.rs1));
            check_eq("head_rs2", 64'(out_rs2), 64'(e.rs2));
            check_eq("head_imm", 64'(out_imm), 64'(e.imm));
            check_eq("head_is_ls", 64'(out_is_ls), 64'(e.ls));
            check_eq("head_is_br", 64'(out_is_br), 64'(e.br));
            check_eq("head_illegal", 64'(out_illegal), 64'(e.ill));
        end
        in_valid = iv;
        in_inst  = tbl[idx].inst;
        in_pc    = cur_pc;
        out_pop  = op;
        flush    = fl;
        rdy_in   = rdy;
        rst_in   = rst;
        if (rst) begin
            mq.delete();
        end else if (rdy) begin
            if (fl) begin
                mq.delete();
            end else begin
                do_push = iv && (mq.size() != DEPTH);
                do_pop  = op && (mq.size() != 0);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back('{pc: cur_pc, idx: idx});
                    cur_pc = cur_pc + 32'd4;
                end
            end
        end
        @(negedge clk_in);
    endtask

    initial begin
        tbl[0]  = mk(32'h00500093, 19, 1, 0, 0, 32'h5, 0, 0, 0);          // addi x1,x0,5
        tbl[1]  = mk(32'h40415193, 27, 3, 2, 0, 32'h4, 0, 0, 0);          // srai x3,x2,4
        tbl[2]  = mk(32'h02415193, 0, 0, 0, 0, 32'h0, 0, 0, 1);           // bad shift funct7
        tbl[3]  = mk(32'hFE208CE3, 5, 0, 1, 2, 32'hFFFFFFF8, 0, 1, 0);    // beq x1,x2,-8
        tbl[4]  = mk(32'h123452B7, 1, 5, 0, 0, 32'h12345000, 0, 0, 0);    // lui x5
        tbl[5]  = mk(32'hFFC12303, 13, 6, 2, 0, 32'hFFFFFFFC, 1, 0, 0);   // lw x6,-4(x2)
        tbl[6]  = mk(32'h0071A423, 18, 0, 3, 7, 32'h8, 1, 0, 0);          // sw x7,8(x3)
        tbl[7]  = mk(32'h40C58533, 29, 10, 11, 12, 32'h0, 0, 0, 0);       // sub x10,x11,x12
        tbl[8]  = mk(32'h010000EF, 3, 1, 0, 0, 32'h10, 0, 0, 0);          // jal x1,+16
        tbl[9]  = mk(32'h00000073, 0, 0, 0, 0, 32'h0, 0, 0, 1);           // ecall: not in subset
        tbl[10] = mk(32'h00003003, 0, 0, 0, 0, 32'h0, 0, 0, 1);           // load funct3 011
        tbl[11] = mk(32'h00001067, 0, 0, 0, 0, 32'h0, 0, 0, 1);           // jalr funct3 001
        tbl[12] = mk(32'hFFFFF117, 2, 2, 0, 0, 32'hFFFFF000, 0, 0, 0);    // auipc x2
        tbl[13] = mk(32'h00002063, 0, 0, 0, 0, 32'h0, 0, 0, 1);           // branch funct3 010
        tbl[14] = mk(32'h01F0D093, 26, 1, 1, 0, 32'h1F, 0, 0, 0);         // srli x1,x1,31

        repeat (2) @(negedge clk_in);

        // Stream every vector through with dispatch popping each cycle
        for (int i = 0; i < NV; i++) cycle(1, i, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 1, 0, 1, 0);

        // Fill to DEPTH; fifth word is held while full, even with a pop
        for (int i = 0; i < 4; i++) cycle(1, i + 3, 0, 0, 1, 0);
        cycle(1, 8, 0, 0, 1, 0);
        cycle(1, 8, 0, 0, 1, 0);
        cycle(1, 8, 1, 0, 1, 0);
        cycle(1, 8, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 1, 0);

        // Flush with simultaneous push and pop at count=3
        for (int i = 0; i < 3; i++) cycle(1, i, 0, 0, 1, 0);
        cycle(1, 4, 1, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Global enable low holds everything; then reset at count=2
        for (int i = 0; i < 2; i++) cycle(1, i + 5, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 7, 1, (i == 1), 0, 0);
        cycle(1, 7, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NV - 1)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
